// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the country-road intersection blocks.
//   - Country signal encodings (same values sig_control drives on CNTRY_SIG)
//   - Debounce FSM state enum used by loop_debounce
//   - TRUE/FALSE single-bit constants
// ---------------------------------------------------------------------------
package traffic_pkg;

  // Signal encodings on the 2-bit country signal bus; 3 is unused.
  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Accepted-level states of the loop detector debouncer.
  typedef enum logic [1:0] {
    DB_LOW      = 2'd0,
    DB_CHK_HIGH = 2'd1,
    DB_HIGH     = 2'd2,
    DB_CHK_LOW  = 2'd3
  } debounceState_t;

endpackage

// File: rtl/loop_debounce.sv
// ---------------------------------------------------------------------------
// loop_debounce
// Synchronizes the raw loop-detector level into the clock domain and
// debounces it. A single-cycle arrive pulse marks each accepted rising level.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   loopRaw_i  asynchronous, possibly bouncing detector level
//   arrive_o   registered one-cycle pulse per accepted car arrival
// ---------------------------------------------------------------------------
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic loopRaw_i,
  output logic arrive_o
);

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CYCLES);

  logic           sync1_q;
  logic           sync2_q;
  logic           loopS;
  logic [3:0]     stable_q;
  logic [3:0]     stableInc;
  logic           arrive_q;
  debounceState_t state_q;

  // Two-flop synchronizer guarding against metastability on the raw input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= FALSE;
      sync2_q <= FALSE;
    end else begin
      sync1_q <= loopRaw_i;
      sync2_q <= sync1_q;
    end
  end

  assign loopS     = sync2_q;
  assign stableInc = stable_q + 4'd1;

  // Debounce FSM. stable_q counts consecutive samples at the candidate level;
  // the transition happens on the sample that makes the run DEBOUNCE_CYCLES
  // long, so with a limit of 1 the first differing sample commits directly.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= DB_LOW;
      stable_q <= 4'd0;
      arrive_q <= FALSE;
    end else begin
      arrive_q <= FALSE;
      unique case (state_q)
        DB_LOW: begin
          if (loopS) begin
            if (DEB_LIMIT == 4'd1) begin
              state_q  <= DB_HIGH;
              arrive_q <= TRUE;
            end else begin
              state_q  <= DB_CHK_HIGH;
              stable_q <= 4'd1;
            end
          end
        end
        DB_CHK_HIGH: begin
          if (!loopS) begin
            state_q <= DB_LOW;
          end else if (stableInc == DEB_LIMIT) begin
            state_q  <= DB_HIGH;
            arrive_q <= TRUE;
          end else begin
            stable_q <= stableInc;
          end
        end
        DB_HIGH: begin
          if (!loopS) begin
            if (DEB_LIMIT == 4'd1) begin
              state_q <= DB_LOW;
            end else begin
              state_q  <= DB_CHK_LOW;
              stable_q <= 4'd1;
            end
          end
        end
        DB_CHK_LOW: begin
          if (loopS) begin
            state_q <= DB_HIGH;
          end else if (stableInc == DEB_LIMIT) begin
            state_q <= DB_LOW;
          end else begin
            stable_q <= stableInc;
          end
        end
        default: state_q <= DB_LOW;
      endcase
    end
  end

  assign arrive_o = arrive_q;

endmodule

// File: rtl/country_car_sensor.sv
// ---------------------------------------------------------------------------
// country_car_sensor
// Produces CAR_ON_CNTRY_RD for sig_control: counts debounced car arrivals on
// the country road and retires one car every DEPART_CYCLES green cycles.
// Ports:
//   CLOCK            system clock
//   CLEAR            synchronous active-high reset
//   LOOP_RAW         raw loop-detector level (asynchronous)
//   CNTRY_SIG        country signal from sig_control (RED/YELLOW/GREEN)
//   CAR_ON_CNTRY_RD  registered, high while the queue is non-empty
//   CAR_COUNT        number of queued cars
//   OVERFLOW         sticky flag, arrival seen while the queue was full
// ---------------------------------------------------------------------------
module country_car_sensor
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int DEPART_CYCLES   = 2,
  parameter int CNT_W           = 4
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             LOOP_RAW,
  input  logic [1:0]       CNTRY_SIG,
  output logic             CAR_ON_CNTRY_RD,
  output logic [CNT_W-1:0] CAR_COUNT,
  output logic             OVERFLOW
);

  localparam logic [3:0]       DEPART_LAST = 4'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             arrive;
  logic             depart;
  logic             timerRun;
  logic [3:0]       departTimer_q, departTimer_d;
  logic [CNT_W-1:0] carCount_q, carCount_d;
  logic             carOn_q;
  logic             overflow_q, overflow_d;

  loop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebounce (
    .clk_i     (CLOCK),
    .reset_i   (CLEAR),
    .loopRaw_i (LOOP_RAW),
    .arrive_o  (arrive)
  );

  // The departure timer only advances while green with cars waiting, so the
  // queue can never be decremented below zero. Any other condition discards
  // partial progress toward the next departure.
  always_comb begin
    timerRun      = (CNTRY_SIG == GREEN) && (carCount_q != '0);
    depart        = timerRun && (departTimer_q == DEPART_LAST);
    departTimer_d = 4'd0;
    if (timerRun && !depart) begin
      departTimer_d = departTimer_q + 4'd1;
    end
  end

  // Queue update: simultaneous arrive and depart cancel out; an arrival on a
  // full queue saturates and latches the sticky overflow flag.
  always_comb begin
    carCount_d = carCount_q;
    overflow_d = overflow_q;
    if (arrive && !depart) begin
      if (carCount_q == CNT_MAX) begin
        overflow_d = TRUE;
      end else begin
        carCount_d = carCount_q + CNT_ONE;
      end
    end else if (depart && !arrive) begin
      carCount_d = carCount_q - CNT_ONE;
    end
  end

  // State registers; the car-present flag is taken from the next count so it
  // moves on the same edge as CAR_COUNT.
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      departTimer_q <= 4'd0;
      carCount_q    <= '0;
      carOn_q       <= FALSE;
      overflow_q    <= FALSE;
    end else begin
      departTimer_q <= departTimer_d;
      carCount_q    <= carCount_d;
      carOn_q       <= (carCount_d != '0);
      overflow_q    <= overflow_d;
    end
  end

  assign CAR_COUNT       = carCount_q;
  assign CAR_ON_CNTRY_RD = carOn_q;
  assign OVERFLOW        = overflow_q;

endmodule

// File: tb/tb_country_car_sensor.sv
// ---------------------------------------------------------------------------
// tb_country_car_sensor
// Self-checking bench for country_car_sensor with default parameters.
// A behavioural model tracks the queue from the raw inputs; a negedge process
// compares every cycle, and directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_country_car_sensor;
  import traffic_pkg::*;

  localparam int DEB     = 3;
  localparam int DEP     = 2;
  localparam int W       = 4;
  localparam int CNT_CAP = (1 << W) - 1;

  logic         clock;
  logic         CLEAR;
  logic         LOOP_RAW;
  logic [1:0]   CNTRY_SIG;
  logic         CAR_ON_CNTRY_RD;
  logic [W-1:0] CAR_COUNT;
  logic         OVERFLOW;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  // Model state: raw-sample delay line, accepted level with run length,
  // pending arrival, departure progress and the queue itself.
  bit mSync1, mSync2, mLevel, mArrPend, mOvf;
  int mRun, mTimer, mCount;

  country_car_sensor #(
    .DEBOUNCE_CYCLES(DEB),
    .DEPART_CYCLES  (DEP),
    .CNT_W          (W)
  ) dut (
    .CLOCK          (clock),
    .CLEAR          (CLEAR),
    .LOOP_RAW       (LOOP_RAW),
    .CNTRY_SIG      (CNTRY_SIG),
    .CAR_ON_CNTRY_RD(CAR_ON_CNTRY_RD),
    .CAR_COUNT      (CAR_COUNT),
    .OVERFLOW       (OVERFLOW)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model advanced at every rising edge from the applied inputs.
  initial begin
    bit loopS, newArr, dep, greenBusy;
    forever begin
      @(posedge clock);
      if (CLEAR) begin
        mSync1 = 0; mSync2 = 0; mLevel = 0; mRun = 0;
        mArrPend = 0; mTimer = 0; mCount = 0; mOvf = 0;
      end else begin
        loopS  = mSync2;
        newArr = 0;
        if (loopS != mLevel) begin
          mRun++;
          if (mRun == DEB) begin
            mLevel = loopS;
            mRun   = 0;
            newArr = loopS;
          end
        end else begin
          mRun = 0;
        end
        greenBusy = (CNTRY_SIG == GREEN) && (mCount > 0);
        dep       = greenBusy && (mTimer == DEP - 1);
        mTimer    = (greenBusy && !dep) ? mTimer + 1 : 0;
        if (mArrPend && !dep) begin
          if (mCount == CNT_CAP) mOvf = 1;
          else mCount++;
        end else if (dep && !mArrPend) begin
          mCount--;
        end
        mArrPend = newArr;
        mSync2   = mSync1;
        mSync1   = LOOP_RAW;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (checkEn) begin
        checkOutput("model CAR_COUNT", int'(CAR_COUNT), mCount);
        checkOutput("model CAR_ON_CNTRY_RD", int'(CAR_ON_CNTRY_RD), int'(mCount != 0));
        checkOutput("model OVERFLOW", int'(OVERFLOW), int'(mOvf));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic raw, input logic [1:0] sig, input int n);
    LOOP_RAW  = raw;
    CNTRY_SIG = sig;
    tick(n);
  endtask

  // One well-separated car: detector high long enough to be accepted,
  // then low long enough for the debouncer to settle back.
  task automatic addCar(input logic [1:0] sig);
    applyStimulus(1'b1, sig, 4);
    applyStimulus(1'b0, sig, 6);
  endtask

  task automatic doClear();
    CLEAR = 1'b1;
    tick(2);
    CLEAR = 1'b0;
  endtask

  initial begin
    int drainExp[6];
    drainExp = '{3, 2, 2, 1, 1, 0};

    CLEAR     = 1'b1;
    LOOP_RAW  = 1'b1;
    CNTRY_SIG = RED;

    // Reset held with the detector active: everything stays zero.
    tick(1);
    checkEn = 1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("reset CAR_COUNT", int'(CAR_COUNT), 0);
      checkOutput("reset CAR_ON", int'(CAR_ON_CNTRY_RD), 0);
      checkOutput("reset OVERFLOW", int'(OVERFLOW), 0);
      tick(1);
    end
    CLEAR = 1'b0;
    tick(5);
    checkOutput("latency edge5 count", int'(CAR_COUNT), 0);
    tick(1);
    checkOutput("latency edge6 count", int'(CAR_COUNT), 1);
    checkOutput("latency edge6 car_on", int'(CAR_ON_CNTRY_RD), 1);
    applyStimulus(1'b0, RED, 8);

    // Glitch rejection: two high cycles are too short, three are enough.
    doClear();
    applyStimulus(1'b1, RED, 2);
    applyStimulus(1'b0, RED, 10);
    checkOutput("glitch count", int'(CAR_COUNT), 0);
    applyStimulus(1'b1, RED, 3);
    applyStimulus(1'b0, RED, 10);
    checkOutput("3-cycle count", int'(CAR_COUNT), 1);
    checkOutput("3-cycle car_on", int'(CAR_ON_CNTRY_RD), 1);

    // Queue three cars on red, then drain on green.
    doClear();
    for (int i = 0; i < 3; i++) addCar(RED);
    checkOutput("queued count", int'(CAR_COUNT), 3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, GREEN, 1);
      checkOutput("drain count", int'(CAR_COUNT), drainExp[i]);
    end
    checkOutput("drain car_on", int'(CAR_ON_CNTRY_RD), 0);

    // Interrupted green discards partial progress.
    doClear();
    addCar(RED);
    addCar(RED);
    applyStimulus(1'b0, GREEN, 1);
    applyStimulus(1'b0, YELLOW, 1);
    checkOutput("interrupted count", int'(CAR_COUNT), 2);
    applyStimulus(1'b0, GREEN, 1);
    checkOutput("regreen edge1 count", int'(CAR_COUNT), 2);
    applyStimulus(1'b0, GREEN, 1);
    checkOutput("regreen edge2 count", int'(CAR_COUNT), 1);
    applyStimulus(1'b0, RED, 2);

    // Arrival lands on the same edge as a departure with one car queued.
    applyStimulus(1'b1, RED, 4);
    applyStimulus(1'b1, GREEN, 1);
    checkOutput("simul pre count", int'(CAR_COUNT), 1);
    applyStimulus(1'b1, GREEN, 1);
    checkOutput("simul count", int'(CAR_COUNT), 1);
    applyStimulus(1'b1, GREEN, 2);
    checkOutput("simul after count", int'(CAR_COUNT), 0);
    applyStimulus(1'b0, RED, 8);

    // Saturation: sixteen cars into a fifteen-deep queue.
    doClear();
    for (int i = 0; i < 15; i++) addCar(RED);
    checkOutput("sat 15 count", int'(CAR_COUNT), 15);
    checkOutput("sat 15 overflow", int'(OVERFLOW), 0);
    addCar(RED);
    checkOutput("sat 16 count", int'(CAR_COUNT), 15);
    checkOutput("sat 16 overflow", int'(OVERFLOW), 1);
    applyStimulus(1'b0, GREEN, 40);
    checkOutput("drained count", int'(CAR_COUNT), 0);
    checkOutput("sticky overflow", int'(OVERFLOW), 1);
    doClear();
    checkOutput("cleared overflow", int'(OVERFLOW), 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
